// File: rtl/i2c_pkg.sv
// Shared I2C definitions: address width, R/W bit encoding and the target state enum.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam logic        I2C_WRITE  = 1'b0;
    localparam logic        I2C_READ   = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRxData,
        StRxAck,
        StTxData,
        StTxAck,
        StWaitStop
    } i2c_state_e;

endpackage

// File: rtl/i2c_target_if.sv
// Bus pins plus parallel byte side of the I2C target endpoint.
interface i2c_target_if;

    logic       scl_in;
    logic       sda_in;
    logic       sda_out;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_out, tx_req, rx_data, rx_valid, busy
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_out, tx_req, rx_data, rx_valid, busy
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line with rise/fall detection.
module i2c_sync_edge (
    input  logic i2c_core_clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_i};
    end

    // Reset to 1: an idle I2C bus is pulled high, so no edge is seen on release.
    always_ff @(posedge i2c_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: fixed address match, unlimited write bytes to rx_data, read bytes from tx_data.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'b1101011
) (
    input  logic         i2c_core_clk,
    input  logic         rst_n,
    i2c_target_if.slave  bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_edge u_scl_sync (
        .i2c_core_clk (i2c_core_clk),
        .rst_n        (rst_n),
        .d_i          (bus.scl_in),
        .level_o      (scl_lvl),
        .rise_o       (scl_rise),
        .fall_o       (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .i2c_core_clk (i2c_core_clk),
        .rst_n        (rst_n),
        .d_i          (bus.sda_in),
        .level_o      (sda_lvl),
        .rise_o       (sda_rise),
        .fall_o       (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       rw_q, rw_d;
    logic       nack_q, nack_d;
    logic       sda_out_q, sda_out_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        rw_d       = rw_q;
        nack_d     = nack_q;
        sda_out_d  = sda_out_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;

        if (stop_det) begin
            state_d   = StIdle;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
            cnt_d     = 3'd0;
            done_d    = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            sda_out_d = 1'b1;
            cnt_d     = 3'd0;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                StAddr, StRxData: begin
                    // done_q marks the 8th rise so the byte is consumed on the following fall.
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) done_d = 1'b1;
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        if (state_q == StAddr) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                rw_d      = shift_q[0];
                                sda_out_d = 1'b0;
                                busy_d    = 1'b1;
                                state_d   = StAddrAck;
                            end else begin
                                sda_out_d = 1'b1;
                                busy_d    = 1'b0;
                                state_d   = StWaitStop;
                            end
                        end else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_out_d  = 1'b0;
                            state_d    = StRxAck;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        cnt_d = 3'd0;
                        if (rw_q == I2C_READ) begin
                            tx_req_d  = 1'b1;
                            shift_d   = bus.tx_data;
                            sda_out_d = bus.tx_data[7];
                            state_d   = StTxData;
                        end else begin
                            sda_out_d = 1'b1;
                            state_d   = StRxData;
                        end
                    end
                end
                StRxAck: begin
                    if (scl_fall) begin
                        sda_out_d = 1'b1;
                        state_d   = StRxData;
                    end
                end
                StTxData: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) done_d = 1'b1;
                    end else if (scl_fall) begin
                        if (done_q) begin
                            done_d    = 1'b0;
                            sda_out_d = 1'b1;
                            state_d   = StTxAck;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_out_d = shift_q[6];
                        end
                    end
                end
                StTxAck: begin
                    if (scl_rise) begin
                        nack_d = sda_lvl;
                    end else if (scl_fall) begin
                        if (!nack_q) begin
                            tx_req_d  = 1'b1;
                            shift_d   = bus.tx_data;
                            sda_out_d = bus.tx_data[7];
                            cnt_d     = 3'd0;
                            state_d   = StTxData;
                        end else begin
                            sda_out_d = 1'b1;
                            state_d   = StWaitStop;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i2c_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= 8'h00;
            cnt_q      <= 3'd0;
            done_q     <= 1'b0;
            rw_q       <= I2C_WRITE;
            nack_q     <= 1'b0;
            sda_out_q  <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
            sda_out_q  <= sda_out_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sda_out  = sda_out_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint that answers transactions from `i2c_controller` on the same bus. Oversamples SCL/SDA on the core clock, detects START/STOP, matches a fixed 7-bit address, ACKs it, then either receives write bytes to a parallel output or serves read bytes from a parallel input. Sits at the bus pins opposite the controller; the parallel side connects to a register file or FIFO.

## Interface
- `TARGET_ADDR`, 7'b1101011, 7-bit bus address this target answers to.
- `i2c_core_clk`  in  1  core clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scl_in`  in  1  raw SCL from the bus (async to core clock).
- `sda_in`  in  1  raw SDA from the bus (async to core clock).
- `sda_out`  out  1  open-drain SDA control: 0 = pull low, 1 = release.
- `tx_data`  in  8  byte returned on a read; sampled when `tx_req` pulses.
- `tx_req`  out  1  one-cycle pulse: `tx_data` captured for the next read byte.
- `rx_data`  out  8  last byte received on a write; held until next byte.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `busy`  out  1  high from address match until STOP or mismatch.

## Operation
- SCL/SDA each pass a 2-flop synchronizer; edge detect on synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both take priority over any state; START -> ADDR (bit counter cleared), STOP -> IDLE. Repeated START mid-transfer is a START.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- Sampling on SCL rising edge, MSB first; `sda_out` changes only on SCL falling edge.
- ADDR: shift 8 bits (7 address + R/W). On 8th-bit SCL fall: match -> ADDR_ACK, pull `sda_out` low, `busy`=1; mismatch -> WAIT_STOP, SDA released.
- ADDR_ACK: on next SCL fall release SDA; R/W=0 -> RX_DATA; R/W=1 -> pulse `tx_req`, load `tx_data` into shifter, drive MSB, go TX_DATA.
- RX_DATA: shift 8 bits; on 8th-bit SCL fall update `rx_data`, pulse `rx_valid`, pull SDA low, go RX_ACK; next SCL fall release, back to RX_DATA. Unlimited bytes.
- TX_DATA: drive next bit on each SCL fall; after 8th bit's SCL fall release SDA, go TX_ACK.
- TX_ACK: sample SDA on SCL rise. 0 (ACK) -> on SCL fall pulse `tx_req`, load, drive MSB, TX_DATA. 1 (NACK) -> WAIT_STOP, SDA released.
- WAIT_STOP: SDA released, ignore bits; leave only on STOP/START.
- Bit counter 3 bits, wraps 7->0 at each byte boundary.

## Timing
- Reset values: `sda_out`=1, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, state IDLE, shifter/counter 0.
- Reset mid-transfer: all outputs return to reset values asynchronously; SDA released immediately.
- Bus event to internal detection: 3 core cycles (2 sync + edge register). `sda_out` update 1 cycle after detection.
- Requires SCL high and low phases each >= 4 core clocks; hold of SDA after SCL fall from controller >= 1 core clock.
- `rx_valid` and `tx_req` are exactly one cycle wide; never both in same cycle.
- STOP in same cycle as any SCL edge: STOP wins. STOP directly after address ACK: `busy` clears, no `rx_valid`.

## Structure
- Package `i2c_pkg`: state enum, `I2C_ADDR_W`=7, R/W bit constants (`I2C_WRITE`=0, `I2C_READ`=1); shared with `i2c_controller`.
- Sub-module `i2c_sync_edge`: 2-flop synchronizer + rise/fall detect, instantiated for SCL and SDA.

## Test plan
- Write: address 0xD6 (1101011.0), byte 0xAA, STOP -> SDA low during both ACK bits, `rx_data`=0xAA with single `rx_valid`, `busy` back to 0.
- Read: address 0xD7, `tx_data`=0x5A, controller NACKs -> SDA carries 0,1,0,1,1,0,1,0; one `tx_req`; SDA released after NACK.
- Multi-byte read: `tx_data` 0x0F then 0xF0, controller ACKs first, NACKs second -> two `tx_req` pulses, bytes match.
- Mismatch: address 0x1E (0001111.0) -> no ACK (SDA stays 1), no `rx_valid`, `busy`=0 until next START.
- Repeated START: write 0xD6 + 0x11, Sr, read 0xD7 -> `rx_data`=0x11, then read byte served correctly.
- Reset asserted mid-byte during read -> `sda_out`=1 immediately, all outputs at reset values; next full write transaction succeeds.
